// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM. A single memory port is shared between
// instruction fetch and load/store. The FSM sequences that port and drives
// the datapath enables, mux selects and ALU op class. A watchdog bounds
// every memory wait, and illegal opcodes and timeouts raise a sticky fault
// that parks the machine until reset.
module multicycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       retire,
    output logic [1:0] fault,
    output logic [3:0] state
);

    // Watchdog counter width: must hold values up to TIMEOUT_CYCLES-1.
    localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Count value seen during the last permitted wait cycle.
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit WD_ENABLE = (TIMEOUT_CYCLES != 0);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_EXECU    = 4'd9,
        S_ALUWB    = 4'd10,
        S_BRANCH   = 4'd11,
        S_JALR     = 4'd12,
        S_JAL      = 4'd13,
        S_ILLEGAL  = 4'd14,
        S_UNUSED   = 4'd15
    } state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    state_t          state_q, state_d;
    logic [1:0]      fault_q, fault_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic mem_wait;
    logic timeout;

    // A wait cycle is one where the port is requested but not completed.
    // The timeout fires on the last permitted wait cycle; a completing
    // mem_ready in that cycle is not a wait, so completion always wins.
    assign mem_wait = mem_req && !mem_ready;
    assign timeout  = WD_ENABLE && mem_wait && (wd_q == WD_LAST);

    // Watchdog next value: count consecutive wait cycles, clear otherwise.
    always_comb begin
        wd_d = '0;
        if (WD_ENABLE && mem_wait && !timeout) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    // State, fault and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            fault_q <= FAULT_NONE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state and output decode. Outputs follow the state; the only
    // input-qualified strobes are the fetch/store completion on mem_ready
    // and the branch-taken PC write.
    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        retire     = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // PC on the address bus; ALU forms PC+4 onto the result bus.
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                // Speculatively compute oldPC+imm for branches and JAL.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    7'b0000011,
                    7'b0100011: state_d = S_MEMADR;
                    7'b0110011: state_d = S_EXECR;
                    7'b0010011: state_d = S_EXECI;
                    7'b1100011: state_d = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
                    7'b1101111: state_d = S_JAL;
                    7'b1100111: state_d = S_JALR;
                    7'b0110111,
                    7'b0010111: state_d = S_EXECU;
                    default:    state_d = S_ILLEGAL;
                endcase
                if (state_d == S_ILLEGAL && fault_q == FAULT_NONE) begin
                    fault_d = FAULT_ILLEGAL;
                end
            end

            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end

            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end

            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end

            S_EXECU: begin
                // LUI adds the immediate to zero; AUIPC adds it to oldPC.
                alu_src_a = opcode[5] ? 2'b11 : 2'b01;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end

            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_BRANCH: begin
                // funct3[0] inverts the sense; funct3[2] selects the
                // less-than compare whose zero flag means "not less".
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero ^ funct3[0] ^ funct3[2];
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JAL;
            end

            S_JAL: begin
                // PC takes the target in ALUOut while the ALU forms oldPC+4
                // for the link write in ALUWB.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end

            S_ILLEGAL: begin
                state_d = S_ILLEGAL;
            end

            default: begin
                // Unreachable encoding behaves as the illegal trap.
                state_d = S_ILLEGAL;
                if (fault_q == FAULT_NONE) begin
                    fault_d = FAULT_ILLEGAL;
                end
            end
        endcase

        // Watchdog expiry aborts the memory access.
        if (timeout) begin
            state_d = S_ILLEGAL;
            if (fault_q == FAULT_NONE) begin
                fault_d = FAULT_TIMEOUT;
            end
        end
    end

    assign fault = fault_q;
    assign state = state_q;

endmodule
